// File: rtl/instr_fetch_unit.sv
// Instruction fetch front-end: credit-limited in-order imem reads
// feeding a show-ahead prefetch FIFO toward decode, with redirect flush.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned MAX_OUT  = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        dec_valid,
  input  logic        dec_ready,
  output logic [31:0] dec_instr,
  output logic [31:0] dec_pc
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned OW = $clog2(MAX_OUT + 1);

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   rsp_pc_q, rsp_pc_d;
  logic [OW-1:0] out_q, out_d;
  logic [OW-1:0] drop_q, drop_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic [AW-1:0] wr_q, rd_q;
  logic [31:0]   pc_mem  [DEPTH];
  logic [31:0]   ins_mem [DEPTH];
  logic          acc, rsp_ok, push, pop;
  logic [31:0]   tgt;

  assign tgt = {redirect_pc[31:2], 2'b00};

  assign imem_req_valid = reset && !redirect_valid
                       && (32'(out_q) < MAX_OUT)
                       && (32'(cnt_q) + 32'(out_q) < DEPTH);
  assign imem_req_addr  = fetch_pc_q;

  assign acc    = imem_req_valid && imem_req_ready;
  assign rsp_ok = imem_rsp_valid && (out_q != '0);
  assign push   = rsp_ok && (drop_q == '0) && !redirect_valid;
  assign pop    = dec_valid && dec_ready && !redirect_valid;

  assign dec_valid = (cnt_q != '0);
  assign dec_instr = dec_valid ? ins_mem[rd_q] : '0;
  assign dec_pc    = dec_valid ? pc_mem[rd_q]  : '0;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    rsp_pc_d   = rsp_pc_q;
    out_d      = out_q + OW'(acc) - OW'(rsp_ok);
    drop_d     = drop_q;
    cnt_d      = cnt_q;
    if (redirect_valid) begin
      fetch_pc_d = tgt;
      rsp_pc_d   = tgt;
      // every read still in flight after this cycle belongs to the old stream
      drop_d     = out_q - OW'(rsp_ok);
      cnt_d      = '0;
    end else begin
      if (acc)
        fetch_pc_d = fetch_pc_q + 32'd4;
      if (rsp_ok && (drop_q != '0))
        drop_d = drop_q - OW'(1);
      if (push)
        rsp_pc_d = rsp_pc_q + 32'd4;
      cnt_d = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc_q <= RESET_PC;
      rsp_pc_q   <= RESET_PC;
      out_q      <= '0;
      drop_q     <= '0;
      cnt_q      <= '0;
      wr_q       <= '0;
      rd_q       <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q   <= rsp_pc_d;
      out_q      <= out_d;
      drop_q     <= drop_d;
      cnt_q      <= cnt_d;
      if (push)
        wr_q <= wr_q + AW'(1);
      if (redirect_valid)
        rd_q <= wr_q;
      else if (pop)
        rd_q <= rd_q + AW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_q]  <= rsp_pc_q;
      ins_mem[wr_q] <= imem_rsp_data;
    end
  end

endmodule
